// File: rtl/vscale_debug_module.sv
// vscale_debug_module: per-hart debug module for the 0.13-style debug interface.
// Decodes DMI reads/writes from the DTM, drives haltreq/resumereq into the core,
// and runs abstract register-access commands (one access cycle, one capture cycle).
// Optional feature macro: VSCALE_DM_AUTOEXEC_EN (abstractauto at 0x18; data0
// accesses re-run the last accepted command). Undefined by default.
module vscale_debug_module #(
    parameter int ABITS       = 7,
    parameter int XLEN        = 32,
    parameter int REGNO_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dmi_req_valid,
    output logic                   dmi_req_ready,
    input  logic [1:0]             dmi_req_op,
    input  logic [ABITS-1:0]       dmi_req_addr,
    input  logic [XLEN-1:0]        dmi_req_data,
    output logic                   dmi_resp_valid,
    input  logic                   dmi_resp_ready,
    output logic [1:0]             dmi_resp_op,
    output logic [XLEN-1:0]        dmi_resp_data,
    output logic                   haltreq,
    input  logic                   haltack,
    output logic                   resumereq,
    input  logic                   resumeack,
    output logic [REGNO_WIDTH-1:0] register_index,
    output logic                   debug_write,
    output logic                   debug_read,
    output logic [XLEN-1:0]        debug_wdata,
    input  logic [XLEN-1:0]        debug_rdata
);

    localparam logic [ABITS-1:0] ADDR_DATA0        = ABITS'(7'h04);
    localparam logic [ABITS-1:0] ADDR_DMCONTROL    = ABITS'(7'h10);
    localparam logic [ABITS-1:0] ADDR_DMSTATUS     = ABITS'(7'h11);
    localparam logic [ABITS-1:0] ADDR_ABSTRACTCS   = ABITS'(7'h16);
    localparam logic [ABITS-1:0] ADDR_COMMAND      = ABITS'(7'h17);
`ifdef VSCALE_DM_AUTOEXEC_EN
    localparam logic [ABITS-1:0] ADDR_ABSTRACTAUTO = ABITS'(7'h18);
`endif

    typedef enum logic {
        DMI_IDLE,
        DMI_RESP
    } dmi_state_t;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_ACCESS,
        CMD_CAPTURE
    } cmd_state_t;

    dmi_state_t             dmi_state_q, dmi_state_d;
    cmd_state_t             cmd_state_q, cmd_state_d;
    logic [1:0]             resp_op_q, resp_op_d;
    logic [XLEN-1:0]        resp_data_q, resp_data_d;
    logic                   dmactive_q, dmactive_d;
    logic                   haltreq_q, haltreq_d;
    logic                   resumereq_q, resumereq_d;
    logic                   halted_q, halted_d;
    logic                   resumeack_seen_q, resumeack_seen_d;
    logic [XLEN-1:0]        data0_q, data0_d;
    logic [2:0]             cmderr_q, cmderr_d;
    logic [REGNO_WIDTH-1:0] regno_q, regno_d;
    logic                   cmd_write_q, cmd_write_d;
`ifdef VSCALE_DM_AUTOEXEC_EN
    logic                   autoexec_q, autoexec_d;
    logic [31:0]            last_cmd_q, last_cmd_d;
`endif

    logic        busy;
    logic        req_fire;
    logic        is_rd;
    logic        is_wr;
    logic        cmd_start;
    logic [31:0] cmd_word;
    logic        unused_cmd;

    assign busy     = (cmd_state_q != CMD_IDLE);
    assign is_rd    = (dmi_req_op == 2'd1);
    assign is_wr    = (dmi_req_op == 2'd2);
    assign req_fire = dmi_req_valid && dmi_req_ready;

    // Only the decoded command fields matter; the rest of the word is don't-care.
    assign unused_cmd = ^cmd_word;

    // Next-state logic: DMI handshake, register decode, halt/resume and command FSM.
    always_comb begin
        dmi_state_d      = dmi_state_q;
        cmd_state_d      = cmd_state_q;
        resp_op_d        = resp_op_q;
        resp_data_d      = resp_data_q;
        dmactive_d       = dmactive_q;
        haltreq_d        = haltreq_q;
        resumereq_d      = resumereq_q;
        halted_d         = halted_q;
        resumeack_seen_d = resumeack_seen_q;
        data0_d          = data0_q;
        cmderr_d         = cmderr_q;
        regno_d          = regno_q;
        cmd_write_d      = cmd_write_q;
`ifdef VSCALE_DM_AUTOEXEC_EN
        autoexec_d       = autoexec_q;
        last_cmd_d       = last_cmd_q;
`endif
        cmd_start        = 1'b0;
        cmd_word         = dmi_req_data[31:0];

        // Core handshake pulses.
        if (haltack) begin
            halted_d = 1'b1;
        end
        if (resumereq_q && resumeack) begin
            resumereq_d      = 1'b0;
            halted_d         = 1'b0;
            resumeack_seen_d = 1'b1;
        end

        // Abstract command sequencing: one access cycle, then one capture cycle.
        case (cmd_state_q)
            CMD_ACCESS:  cmd_state_d = CMD_CAPTURE;
            CMD_CAPTURE: begin
                if (!cmd_write_q) begin
                    data0_d = debug_rdata;
                end
                cmd_state_d = CMD_IDLE;
            end
            default:     cmd_state_d = cmd_state_q;
        endcase

        // DMI request/response; the response is registered for the next cycle.
        case (dmi_state_q)
            DMI_IDLE: begin
                if (req_fire) begin
                    dmi_state_d = DMI_RESP;
                    resp_op_d   = 2'd0;
                    resp_data_d = '0;
                    case (dmi_req_addr)
                        ADDR_DATA0: begin
                            if (is_rd) begin
                                resp_data_d = data0_q;
                            end
                            if (is_wr && dmactive_q) begin
                                if (busy) begin
                                    if (cmderr_q == 3'd0) cmderr_d = 3'd1;
                                end else begin
                                    data0_d = dmi_req_data;
                                end
                            end
`ifdef VSCALE_DM_AUTOEXEC_EN
                            if ((is_rd || is_wr) && dmactive_q && autoexec_q &&
                                !busy && (cmderr_q == 3'd0)) begin
                                cmd_start = 1'b1;
                                cmd_word  = last_cmd_q;
                            end
`endif
                        end
                        ADDR_DMCONTROL: begin
                            if (is_rd) begin
                                resp_data_d = XLEN'({haltreq_q, resumereq_q, 29'd0, dmactive_q});
                            end
                            if (is_wr) begin
                                dmactive_d = dmi_req_data[0];
                                haltreq_d  = dmi_req_data[31];
                                // A simultaneous haltreq wins over resumereq.
                                if (dmi_req_data[30] && !dmi_req_data[31] && halted_q) begin
                                    resumereq_d      = 1'b1;
                                    resumeack_seen_d = 1'b0;
                                end
                            end
                        end
                        ADDR_DMSTATUS: begin
                            if (is_rd) begin
                                resp_data_d = XLEN'({14'd0,
                                                     resumeack_seen_q, resumeack_seen_q,
                                                     4'd0,
                                                     !halted_q, !halted_q,
                                                     halted_q, halted_q,
                                                     1'b1, 3'd0, 4'd2});
                            end
                        end
                        ADDR_ABSTRACTCS: begin
                            if (is_rd) begin
                                resp_data_d = XLEN'({19'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd1});
                            end
                            if (is_wr && dmactive_q) begin
                                cmderr_d = cmderr_q & ~dmi_req_data[10:8];
                            end
                        end
                        ADDR_COMMAND: begin
                            if (is_wr && dmactive_q) begin
                                cmd_start = 1'b1;
                                cmd_word  = dmi_req_data[31:0];
                            end
                        end
`ifdef VSCALE_DM_AUTOEXEC_EN
                        ADDR_ABSTRACTAUTO: begin
                            if (is_rd) begin
                                resp_data_d = XLEN'({31'd0, autoexec_q});
                            end
                            if (is_wr && dmactive_q) begin
                                autoexec_d = dmi_req_data[0];
                            end
                        end
`endif
                        default: resp_op_d = 2'd2;
                    endcase
                end
            end
            default: begin
                if (dmi_resp_ready) begin
                    dmi_state_d = DMI_IDLE;
                end
            end
        endcase

        // Command acceptance checks, in priority order.
        if (cmd_start) begin
            if (busy) begin
                if (cmderr_q == 3'd0) cmderr_d = 3'd1;
            end else if (cmderr_q != 3'd0) begin
                cmderr_d = cmderr_q;
            end else if ((cmd_word[31:24] != 8'd0) || (cmd_word[22:20] != 3'd2)) begin
                cmderr_d = 3'd2;
            end else if (!halted_q) begin
                cmderr_d = 3'd4;
            end else begin
`ifdef VSCALE_DM_AUTOEXEC_EN
                last_cmd_d = cmd_word;
`endif
                if (cmd_word[17]) begin
                    cmd_state_d = CMD_ACCESS;
                    regno_d     = cmd_word[REGNO_WIDTH-1:0];
                    cmd_write_d = cmd_word[16];
                end
            end
        end

        // An inactive DM keeps all of its state at reset value.
        if (!dmactive_d) begin
            haltreq_d        = 1'b0;
            resumereq_d      = 1'b0;
            halted_d         = 1'b0;
            resumeack_seen_d = 1'b0;
            data0_d          = '0;
            cmderr_d         = 3'd0;
            cmd_state_d      = CMD_IDLE;
            regno_d          = '0;
            cmd_write_d      = 1'b0;
`ifdef VSCALE_DM_AUTOEXEC_EN
            autoexec_d       = 1'b0;
            last_cmd_d       = 32'd0;
`endif
        end
    end

    // State registers with synchronous reset; reset also drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmi_state_q      <= DMI_IDLE;
            cmd_state_q      <= CMD_IDLE;
            resp_op_q        <= 2'd0;
            resp_data_q      <= '0;
            dmactive_q       <= 1'b0;
            haltreq_q        <= 1'b0;
            resumereq_q      <= 1'b0;
            halted_q         <= 1'b0;
            resumeack_seen_q <= 1'b0;
            data0_q          <= '0;
            cmderr_q         <= 3'd0;
            regno_q          <= '0;
            cmd_write_q      <= 1'b0;
`ifdef VSCALE_DM_AUTOEXEC_EN
            autoexec_q       <= 1'b0;
            last_cmd_q       <= 32'd0;
`endif
        end else begin
            dmi_state_q      <= dmi_state_d;
            cmd_state_q      <= cmd_state_d;
            resp_op_q        <= resp_op_d;
            resp_data_q      <= resp_data_d;
            dmactive_q       <= dmactive_d;
            haltreq_q        <= haltreq_d;
            resumereq_q      <= resumereq_d;
            halted_q         <= halted_d;
            resumeack_seen_q <= resumeack_seen_d;
            data0_q          <= data0_d;
            cmderr_q         <= cmderr_d;
            regno_q          <= regno_d;
            cmd_write_q      <= cmd_write_d;
`ifdef VSCALE_DM_AUTOEXEC_EN
            autoexec_q       <= autoexec_d;
            last_cmd_q       <= last_cmd_d;
`endif
        end
    end

    assign dmi_req_ready  = (dmi_state_q == DMI_IDLE) && !reset;
    assign dmi_resp_valid = (dmi_state_q == DMI_RESP);
    assign dmi_resp_op    = resp_op_q;
    assign dmi_resp_data  = resp_data_q;
    assign haltreq        = haltreq_q;
    assign resumereq      = resumereq_q;
    assign register_index = regno_q;
    assign debug_write    = (cmd_state_q == CMD_ACCESS) && cmd_write_q;
    assign debug_read     = (cmd_state_q == CMD_ACCESS) && !cmd_write_q;
    assign debug_wdata    = data0_q;

endmodule

// File: tb/tb_vscale_debug_module.sv
// tb_vscale_debug_module: directed, table-driven check of the debug module.
module tb_vscale_debug_module;

    logic        clk;
    logic        reset;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [1:0]  dmi_resp_op;
    logic [31:0] dmi_resp_data;
    logic        haltreq;
    logic        haltack;
    logic        resumereq;
    logic        resumeack;
    logic [12:0] register_index;
    logic        debug_write;
    logic        debug_read;
    logic [31:0] debug_wdata;
    logic [31:0] debug_rdata;

    vscale_debug_module #(.ABITS(7), .XLEN(32), .REGNO_WIDTH(13)) dut (
        .clk            (clk),
        .reset          (reset),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_op     (dmi_req_op),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_op    (dmi_resp_op),
        .dmi_resp_data  (dmi_resp_data),
        .haltreq        (haltreq),
        .haltack        (haltack),
        .resumereq      (resumereq),
        .resumeack      (resumeack),
        .register_index (register_index),
        .debug_write    (debug_write),
        .debug_read     (debug_read),
        .debug_wdata    (debug_wdata),
        .debug_rdata    (debug_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  exp_op;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    vec_t tab[11];

    int total  = 0;
    int passed = 0;

    // Core-side strobe monitor, sampled mid-cycle.
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [12:0] last_idx = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (debug_write) begin
            wr_cnt     = wr_cnt + 1;
            last_idx   = register_index;
            last_wdata = debug_wdata;
        end
        if (debug_read) begin
            rd_cnt = rd_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One DMI transaction; called and returns on a falling edge.
    task automatic dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                       output logic [1:0] rop, output logic [31:0] rdata);
        int n;
        dmi_req_valid = 1'b1;
        dmi_req_op    = op;
        dmi_req_addr  = addr;
        dmi_req_data  = data;
        n = 0;
        while (!dmi_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!dmi_req_ready) check("req_ready_timeout", 32'(dmi_req_ready), 32'd1);
        @(negedge clk);
        dmi_req_valid  = 1'b0;
        dmi_req_op     = 2'd0;
        dmi_resp_ready = 1'b1;
        n = 0;
        while (!dmi_resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!dmi_resp_valid) check("resp_valid_timeout", 32'(dmi_resp_valid), 32'd1);
        rop   = dmi_resp_op;
        rdata = dmi_resp_data;
        @(negedge clk);
        dmi_resp_ready = 1'b0;
    endtask

    task automatic xchk(input string name, input logic [1:0] op, input logic [6:0] addr,
                        input logic [31:0] data, input logic [1:0] eop, input logic [31:0] edata);
        logic [1:0]  rop;
        logic [31:0] rdata;
        dmi(op, addr, data, rop, rdata);
        $display("dmi %s op=%0d addr=%h wdata=%h -> resp_op=%0d data=%h",
                 name, op, addr, data, rop, rdata);
        check({name, "_op"}, 32'(rop), 32'(eop));
        check({name, "_data"}, rdata, edata);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            xchk(tab[i].name, tab[i].op, tab[i].addr, tab[i].wdata, tab[i].exp_op, tab[i].exp_data);
        end
    endtask

    task automatic halt_core();
        xchk("dmctl_halt", 2'd2, 7'h10, 32'h8000_0001, 2'd0, 32'h0);
        check("haltreq_after_write", 32'(haltreq), 32'd1);
        repeat (5) @(negedge clk);
        haltack = 1'b1;
        @(negedge clk);
        haltack = 1'b0;
    endtask

    initial begin
        int w0;
        int r0;
        int hi_cycles;

        tab[0]  = '{2'd1, 7'h11, 32'h0,         2'd0, 32'h0000_0C82, "dmstatus_reset"};
        tab[1]  = '{2'd1, 7'h16, 32'h0,         2'd0, 32'h0000_0001, "abstractcs_reset"};
        tab[2]  = '{2'd2, 7'h04, 32'h0000_0055, 2'd0, 32'h0,         "data0_wr_inactive"};
        tab[3]  = '{2'd1, 7'h04, 32'h0,         2'd0, 32'h0,         "data0_rd_inactive"};
        tab[4]  = '{2'd1, 7'h2A, 32'h0,         2'd2, 32'h0,         "unmapped_rd"};
        tab[5]  = '{2'd2, 7'h3F, 32'h1,         2'd2, 32'h0,         "unmapped_wr"};
        tab[6]  = '{2'd2, 7'h04, 32'hDEAD_BEEF, 2'd0, 32'h0,         "data0_wr"};
        tab[7]  = '{2'd1, 7'h04, 32'h0,         2'd0, 32'hDEAD_BEEF, "data0_rd"};
        tab[8]  = '{2'd1, 7'h11, 32'h0,         2'd0, 32'h0000_0382, "dmstatus_halted"};
        tab[9]  = '{2'd1, 7'h10, 32'h0,         2'd0, 32'h0000_0001, "dmcontrol_rd"};
        tab[10] = '{2'd1, 7'h17, 32'h0,         2'd0, 32'h0,         "command_rd"};

        reset          = 1'b1;
        dmi_req_valid  = 1'b0;
        dmi_req_op     = 2'd0;
        dmi_req_addr   = '0;
        dmi_req_data   = '0;
        dmi_resp_ready = 1'b0;
        haltack        = 1'b0;
        resumeack      = 1'b0;
        debug_rdata    = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_haltreq", 32'(haltreq), 32'd0);
        check("rst_resumereq", 32'(resumereq), 32'd0);
        check("rst_strobes", 32'({debug_write, debug_read}), 32'd0);
        check("rst_regidx", 32'(register_index), 32'd0);
        check("rst_wdata", debug_wdata, 32'd0);
        check("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(dmi_req_ready), 32'd1);

        // Inactive DM: reset values, ignored writes, unmapped addresses.
        run_table(0, 5);

        // Halt: haltreq stays up across the ack until written 0.
        halt_core();
        check("haltreq_held", 32'(haltreq), 32'd1);
        xchk("dmctl_clr_halt", 2'd2, 7'h10, 32'h0000_0001, 2'd0, 32'h0);
        check("haltreq_cleared", 32'(haltreq), 32'd0);
        run_table(6, 10);

        // Register write command; busy visible to the very next DMI request.
        w0 = wr_cnt; r0 = rd_cnt;
        xchk("cmd_write_r5", 2'd2, 7'h17, 32'h0023_0005, 2'd0, 32'h0);
        xchk("abscs_busy", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_1001);
        xchk("abscs_idle", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_0001);
        check("wr_strobe_count", 32'(wr_cnt - w0), 32'd1);
        check("rd_strobe_count_w", 32'(rd_cnt - r0), 32'd0);
        check("wr_regidx", 32'(last_idx), 32'd5);
        check("wr_wdata", last_wdata, 32'hDEAD_BEEF);

        // data0 write while busy is dropped and flags cmderr=1.
        xchk("cmd_write_r6", 2'd2, 7'h17, 32'h0023_0006, 2'd0, 32'h0);
        xchk("data0_wr_busy", 2'd2, 7'h04, 32'h1111_1111, 2'd0, 32'h0);
        xchk("abscs_err1", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_0101);
        xchk("data0_kept", 2'd1, 7'h04, 32'h0, 2'd0, 32'hDEAD_BEEF);
        xchk("abscs_w1c", 2'd2, 7'h16, 32'h0000_0100, 2'd0, 32'h0);
        xchk("abscs_clr1", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_0001);

        // Register read command; a data0 read during capture returns the old value.
        debug_rdata = 32'h1234_5678;
        r0 = rd_cnt;
        xchk("cmd_read_r5", 2'd2, 7'h17, 32'h0022_0005, 2'd0, 32'h0);
        xchk("data0_stale", 2'd1, 7'h04, 32'h0, 2'd0, 32'hDEAD_BEEF);
        xchk("data0_captured", 2'd1, 7'h04, 32'h0, 2'd0, 32'h1234_5678);
        check("rd_strobe_count", 32'(rd_cnt - r0), 32'd1);

        // Unsupported cmdtype.
        xchk("cmd_bad_type", 2'd2, 7'h17, 32'h0122_0005, 2'd0, 32'h0);
        xchk("abscs_err2", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_0201);
        xchk("abscs_clr2", 2'd2, 7'h16, 32'h0000_0700, 2'd0, 32'h0);

        // haltreq and resumereq together: halt wins.
        xchk("dmctl_both", 2'd2, 7'h10, 32'hC000_0001, 2'd0, 32'h0);
        check("both_haltreq", 32'(haltreq), 32'd1);
        check("both_resumereq", 32'(resumereq), 32'd0);
        xchk("dmctl_clr_both", 2'd2, 7'h10, 32'h0000_0001, 2'd0, 32'h0);

        // Resume: resumereq holds until the ack pulse.
        xchk("dmctl_resume", 2'd2, 7'h10, 32'h4000_0001, 2'd0, 32'h0);
        hi_cycles = 0;
        repeat (4) begin
            if (resumereq) hi_cycles++;
            @(negedge clk);
        end
        check("resumereq_held", 32'(hi_cycles), 32'd4);
        resumeack = 1'b1;
        @(negedge clk);
        resumeack = 1'b0;
        check("resumereq_dropped", 32'(resumereq), 32'd0);
        xchk("dmstatus_resumed", 2'd1, 7'h11, 32'h0, 2'd0, 32'h0003_0C82);

        // Resume while running is ignored.
        xchk("dmctl_resume_run", 2'd2, 7'h10, 32'h4000_0001, 2'd0, 32'h0);
        check("resume_ignored", 32'(resumereq), 32'd0);
        xchk("dmstatus_still", 2'd1, 7'h11, 32'h0, 2'd0, 32'h0003_0C82);

        // Command while running: cmderr=4, no strobe.
        r0 = rd_cnt;
        xchk("cmd_running", 2'd2, 7'h17, 32'h0022_0001, 2'd0, 32'h0);
        xchk("abscs_err4", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_0401);
        check("no_strobe_running", 32'(rd_cnt - r0), 32'd0);
        xchk("abscs_clr4", 2'd2, 7'h16, 32'h0000_0700, 2'd0, 32'h0);
        xchk("abscs_clr4_rd", 2'd1, 7'h16, 32'h0, 2'd0, 32'h0000_0001);

        // Reset in the middle of a command with haltreq up and a response pending.
        halt_core();
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd2;
        dmi_req_addr  = 7'h17;
        dmi_req_data  = 32'h0023_0009;
        @(negedge clk);
        dmi_req_valid = 1'b0;
        dmi_req_op    = 2'd0;
        check("mid_cmd_strobe", 32'(debug_write), 32'd1);
        check("mid_cmd_resp_pending", 32'(dmi_resp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_strobe", 32'(debug_write), 32'd0);
        check("abort_haltreq", 32'(haltreq), 32'd0);
        check("abort_resp", 32'(dmi_resp_valid), 32'd0);
        @(negedge clk);
        xchk("dmstatus_after_abort", 2'd1, 7'h11, 32'h0, 2'd0, 32'h0000_0C82);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
